// File: rtl/letc_core_rf_wport_arb.sv
// Register-file write-port arbiter: shares the single rd write port between
// the writeback stage and a small in-order FIFO of out-of-band AUX results.
module letc_core_rf_wport_arb #(
  parameter int unsigned AUX_DEPTH    = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_w_valid,
  input  logic [4:0]  i_w_rd_idx,
  input  logic [31:0] i_w_rd_wdata,
  output logic        o_w_stall,
  input  logic        i_aux_valid,
  output logic        o_aux_ready,
  input  logic [4:0]  i_aux_rd_idx,
  input  logic [31:0] i_aux_rd_wdata,
  output logic [4:0]  o_rd_idx,
  output logic [31:0] o_rd_wdata,
  output logic        o_rd_wen,
  output logic [31:0] o_aux_busy_mask
);

  localparam int unsigned IDX_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PTR_W  = $clog2(AUX_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned STV_W  = $clog2(STARVE_LIMIT + 1);

  logic [IDX_W-1:0]  idx_q  [AUX_DEPTH];
  logic [DATA_W-1:0] data_q [AUX_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic [STV_W-1:0]  starve;
  logic [STV_W-1:0]  starve_nxt;

  logic empty;
  logic force_aux;
  logic grant_aux;
  logic grant_w;
  logic push;
  logic pop;

  assign empty       = (count == '0);
  assign o_aux_ready = (count != CNT_W'(AUX_DEPTH));
  assign force_aux   = (starve == STV_W'(STARVE_LIMIT)) && !empty;
  assign grant_aux   = force_aux || (!i_w_valid && !empty);
  assign grant_w     = !force_aux && i_w_valid;
  // x0 pushes complete the handshake but are never stored
  assign push        = i_aux_valid && o_aux_ready && (i_aux_rd_idx != '0);
  assign pop         = grant_aux;

  // Write-port mux and W back-pressure
  always_comb begin
    o_rd_idx   = '0;
    o_rd_wdata = '0;
    o_w_stall  = force_aux && i_w_valid;
    if (grant_aux) begin
      o_rd_idx   = idx_q[rd_ptr];
      o_rd_wdata = data_q[rd_ptr];
    end else if (grant_w) begin
      o_rd_idx   = i_w_rd_idx;
      o_rd_wdata = i_w_rd_wdata;
    end
    o_rd_wen = (grant_aux || grant_w) && (o_rd_idx != '0);
  end

  // Occupancy and starvation bookkeeping
  always_comb begin
    count_nxt  = count;
    starve_nxt = starve;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
    if (empty || grant_aux) begin
      starve_nxt = '0;
    end else if (starve != STV_W'(STARVE_LIMIT)) begin
      starve_nxt = starve + STV_W'(1);
    end
  end

  // Hazard mask over live entries only; slot i is live if within count of rd_ptr
  always_comb begin
    logic [PTR_W-1:0] off;
    off             = '0;
    o_aux_busy_mask = '0;
    for (int unsigned i = 0; i < AUX_DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr;
      if (CNT_W'(off) < count) begin
        o_aux_busy_mask[idx_q[i]] = 1'b1;
      end
    end
    o_aux_busy_mask[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      starve <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count  <= count_nxt;
      starve <= starve_nxt;
    end
  end

  // Payload storage needs no reset; liveness is tracked by count/pointers
  always_ff @(posedge i_clk) begin
    if (push) begin
      idx_q[wr_ptr]  <= i_aux_rd_idx;
      data_q[wr_ptr] <= i_aux_rd_wdata;
    end
  end

endmodule

// File: tb/tb_letc_core_rf_wport_arb.sv
// Directed bench for the rd write-port arbiter (AUX_DEPTH=2, STARVE_LIMIT=4).
module tb_letc_core_rf_wport_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        w_valid;
  logic [4:0]  w_rd_idx;
  logic [31:0] w_rd_wdata;
  logic        w_stall;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_rd_idx;
  logic [31:0] aux_rd_wdata;
  logic [4:0]  rd_idx;
  logic [31:0] rd_wdata;
  logic        rd_wen;
  logic [31:0] busy_mask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  letc_core_rf_wport_arb #(.AUX_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_w_valid      (w_valid),
    .i_w_rd_idx     (w_rd_idx),
    .i_w_rd_wdata   (w_rd_wdata),
    .o_w_stall      (w_stall),
    .i_aux_valid    (aux_valid),
    .o_aux_ready    (aux_ready),
    .i_aux_rd_idx   (aux_rd_idx),
    .i_aux_rd_wdata (aux_rd_wdata),
    .o_rd_idx       (rd_idx),
    .o_rd_wdata     (rd_wdata),
    .o_rd_wen       (rd_wen),
    .o_aux_busy_mask(busy_mask)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input logic v, input logic [4:0] idx, input logic [31:0] d);
    w_valid = v; w_rd_idx = idx; w_rd_wdata = d;
  endtask

  task automatic set_aux(input logic v, input logic [4:0] idx, input logic [31:0] d);
    aux_valid = v; aux_rd_idx = idx; aux_rd_wdata = d;
  endtask

  task automatic chk_port(input string tag, input logic wen, input logic [4:0] idx,
                          input logic [31:0] d, input logic stall);
    chk({tag, "_wen"}, 32'(rd_wen), 32'(wen));
    chk({tag, "_idx"}, 32'(rd_idx), 32'(idx));
    chk({tag, "_wdata"}, rd_wdata, d);
    chk({tag, "_stall"}, 32'(w_stall), 32'(stall));
  endtask

  task automatic chk_reset(input string tag);
    chk_port(tag, 1'b0, 5'd0, 32'h0, 1'b0);
    chk({tag, "_ready"}, 32'(aux_ready), 32'h1);
    chk({tag, "_mask"}, busy_mask, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    set_w(1'b0, 5'd0, 32'h0);
    set_aux(1'b0, 5'd0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;
    tick();

    // W write of x5 appears the same cycle
    set_w(1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    chk_port("w_x5", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    tick();
    set_w(1'b0, 5'd0, 32'h0);

    // AUX x7 push with W idle: written one cycle later
    set_aux(1'b1, 5'd7, 32'h11);
    #1;
    chk("aux7_c0_ready", 32'(aux_ready), 32'h1);
    chk("aux7_c0_wen", 32'(rd_wen), 32'h0);
    tick();
    set_aux(1'b0, 5'd0, 32'h0);
    #1;
    chk_port("aux7_c1", 1'b1, 5'd7, 32'h11, 1'b0);
    chk("aux7_c1_mask", busy_mask, 32'h0000_0080);
    tick();
    chk("aux7_c2_mask", busy_mask, 32'h0);
    chk("aux7_c2_wen", 32'(rd_wen), 32'h0);

    // Starvation forcing with W continuously valid
    set_w(1'b1, 5'd10, 32'hA0);
    set_aux(1'b1, 5'd3, 32'h33);
    #1;
    chk_port("stv_c0", 1'b1, 5'd10, 32'hA0, 1'b0);
    tick();
    set_aux(1'b1, 5'd4, 32'h44);
    #1;
    chk("stv_c1_ready", 32'(aux_ready), 32'h1);
    chk_port("stv_c1", 1'b1, 5'd10, 32'hA0, 1'b0);
    tick();
    set_aux(1'b0, 5'd0, 32'h0);
    for (int c = 2; c <= 4; c++) begin
      #1;
      chk_port($sformatf("stv_c%0d", c), 1'b1, 5'd10, 32'hA0, 1'b0);
      chk($sformatf("stv_c%0d_ready", c), 32'(aux_ready), 32'h0);
      chk($sformatf("stv_c%0d_mask", c), busy_mask, 32'h0000_0018);
      tick();
    end
    #1;
    chk_port("stv_c5_force_x3", 1'b1, 5'd3, 32'h33, 1'b1);
    tick();
    for (int c = 6; c <= 9; c++) begin
      #1;
      chk_port($sformatf("stv_c%0d", c), 1'b1, 5'd10, 32'hA0, 1'b0);
      chk($sformatf("stv_c%0d_mask", c), busy_mask, 32'h0000_0010);
      chk($sformatf("stv_c%0d_ready", c), 32'(aux_ready), 32'h1);
      tick();
    end
    #1;
    chk_port("stv_c10_force_x4", 1'b1, 5'd4, 32'h44, 1'b1);
    tick();
    #1;
    chk_port("stv_c11", 1'b1, 5'd10, 32'hA0, 1'b0);
    chk("stv_c11_mask", busy_mask, 32'h0);
    set_w(1'b0, 5'd0, 32'h0);
    tick();

    // x0 push: accepted, never stored or written
    set_aux(1'b1, 5'd0, 32'hFF);
    #1;
    chk("x0_c0_ready", 32'(aux_ready), 32'h1);
    tick();
    set_aux(1'b0, 5'd0, 32'h0);
    for (int c = 1; c <= 2; c++) begin
      #1;
      chk_port($sformatf("x0_c%0d", c), 1'b0, 5'd0, 32'h0, 1'b0);
      chk($sformatf("x0_c%0d_mask", c), busy_mask, 32'h0);
      chk($sformatf("x0_c%0d_ready", c), 32'(aux_ready), 32'h1);
      tick();
    end

    // Full FIFO: x9 rejected, then accepted and drained in order
    set_w(1'b1, 5'd12, 32'hC0);
    set_aux(1'b1, 5'd1, 32'h1111);
    #1;
    chk_port("full_c0", 1'b1, 5'd12, 32'hC0, 1'b0);
    tick();
    set_aux(1'b1, 5'd2, 32'h2222);
    #1;
    chk_port("full_c1", 1'b1, 5'd12, 32'hC0, 1'b0);
    tick();
    set_w(1'b0, 5'd0, 32'h0);
    set_aux(1'b1, 5'd9, 32'h99);
    #1;
    chk("full_c2_ready", 32'(aux_ready), 32'h0);
    chk("full_c2_mask", busy_mask, 32'h0000_0006);
    chk_port("full_c2_pop_x1", 1'b1, 5'd1, 32'h1111, 1'b0);
    tick();
    #1;
    chk("full_c3_ready", 32'(aux_ready), 32'h1);
    chk_port("full_c3_pop_x2", 1'b1, 5'd2, 32'h2222, 1'b0);
    tick();
    set_aux(1'b0, 5'd0, 32'h0);
    #1;
    chk_port("full_c4_pop_x9", 1'b1, 5'd9, 32'h99, 1'b0);
    chk("full_c4_mask", busy_mask, 32'h0000_0200);
    tick();
    chk_port("full_c5_idle", 1'b0, 5'd0, 32'h0, 1'b0);
    chk("full_c5_mask", busy_mask, 32'h0);

    // Async reset with two queued entries and starve counter at 3
    set_w(1'b1, 5'd10, 32'hA0);
    set_aux(1'b1, 5'd5, 32'h55);
    tick();
    set_aux(1'b1, 5'd6, 32'h66);
    tick();
    set_aux(1'b0, 5'd0, 32'h0);
    tick();
    tick();
    chk("rst_pre_mask", busy_mask, 32'h0000_0060);
    chk_port("rst_pre", 1'b1, 5'd10, 32'hA0, 1'b0);
    set_w(1'b0, 5'd0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk_reset("rst_mid");
    #2;
    rst_n = 1'b1;
    tick();
    for (int c = 0; c < 6; c++) begin
      #1;
      chk_reset($sformatf("rst_post_c%0d", c));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/letc_core_rf_wport_arb.md
# letc_core_rf_wport_arb

Register-file write-port arbiter for the LETC core. It shares the single rd write port between two sources. The in-order writeback stage (W) always has a request path. An out-of-band requester (AUX: multi-cycle divider results, late load returns) is buffered in a small FIFO. It sits between W / the AUX producers and the integer register file. It exposes a busy mask for the hazard unit and a stall request back to W so that AUX results cannot starve.

## Interface

Parameters:
- AUX_DEPTH, 2, AUX FIFO entries; power of two, ≥2
- STARVE_LIMIT, 4, consecutive denied cycles of a non-empty FIFO before AUX is forced; ≥1

Ports:
- i_clk  in  1  core clock
- i_rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- i_w_valid  in  1  W has an rd write this cycle
- i_w_rd_idx  in  reg_idx_t  W destination register
- i_w_rd_wdata  in  word_t  W write data
- o_w_stall  out  1  W must hold its request; W's write is not performed this cycle
- i_aux_valid  in  1  AUX push request
- o_aux_ready  out  1  FIFO can accept; push happens when i_aux_valid & o_aux_ready
- i_aux_rd_idx  in  reg_idx_t  AUX destination register
- i_aux_rd_wdata  in  word_t  AUX write data
- o_rd_idx  out  reg_idx_t  register-file write index
- o_rd_wdata  out  word_t  register-file write data
- o_rd_wen  out  1  register-file write enable
- o_aux_busy_mask  out  32  bit i set iff a stored FIFO entry targets xi

## Operation

- AUX FIFO: circular, with read and write pointers of $clog2(AUX_DEPTH) bits that wrap. There is a count of $clog2(AUX_DEPTH)+1 bits.
- o_aux_ready = (count != AUX_DEPTH). It is purely from registered state and does not depend on same-cycle pops.
- Push with i_aux_rd_idx == 0: the handshake completes, but nothing is stored (x0 write discarded).
- No bypass: a pushed entry is eligible for grant starting the next cycle.
- Starvation counter: $clog2(STARVE_LIMIT+1) bits.
  - Increments when the FIFO is non-empty and AUX is not granted.
  - Clears on any AUX grant, or whenever the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- force = (starve counter == STARVE_LIMIT) & FIFO non-empty.
- Grant, evaluated combinationally each cycle:
  - force: grant AUX (pop head), and o_w_stall = i_w_valid.
  - else if i_w_valid: grant W, o_w_stall = 0.
  - else if FIFO non-empty: grant AUX (pop head).
  - else: no grant, o_rd_wen = 0.
- On grant, o_rd_idx/o_rd_wdata come from the winner. o_rd_wen = 1 unless the winning idx is 0.
- When there is no grant, o_rd_idx = 0 and o_rd_wdata = 0.
- W writes to x0 win arbitration normally but drive o_rd_wen = 0.
- AUX entries drain strictly in push order.
- Pop and push in the same cycle are both performed. Count is unchanged when both occur and the pushed idx ≠ 0.
- o_aux_busy_mask = OR over valid entries of the one-hot decode of their idx. Bit 0 is always 0. Duplicate targets keep the bit set until the last such entry pops. The mask reflects registered FIFO state only, so same-cycle pushes are not included.
- W ordering hazards (AUX and W targeting the same rd) are the hazard unit's responsibility via o_aux_busy_mask. The arbiter does not reorder or merge.

## Timing

- Reset values: FIFO empty, pointers 0, starve counter 0, o_aux_ready = 1, o_aux_busy_mask = 0, o_rd_wen = 0, o_rd_idx = 0, o_rd_wdata = 0, o_w_stall = 0.
- Reset asserted mid-operation discards all FIFO contents immediately. Accepted AUX results are lost; upstream is reset alongside.
- Outputs o_rd_*, o_w_stall: combinational from inputs and registered state. The register file samples them at the next i_clk edge.
- AUX latency: minimum 1 cycle from accepted push to o_rd_wen (empty FIFO, W idle).
- Worst-case AUX head wait with W continuously valid: STARVE_LIMIT cycles denied, then granted on cycle STARVE_LIMIT+1.
- o_w_stall is asserted for exactly one cycle per forced grant. The counter then clears.
- Full FIFO: o_aux_ready = 0 for the whole cycle even if a pop occurs. Ready reasserts the cycle after the pop.

## Test plan

- Reset, idle, then W writes x5 = 0xDEADBEEF: o_rd_wen = 1, o_rd_idx = 5, o_rd_wdata = 0xDEADBEEF in the same cycle; o_w_stall = 0.
- W idle, AUX pushes x7 = 0x11 at cycle 0:
  - cycle 1: o_rd_wen = 1, idx 7, data 0x11, o_aux_busy_mask bit 7 = 1.
  - cycle 2: mask = 0.
- AUX pushes x3 and x4 (FIFO full) while W continuously valid:
  - o_aux_ready = 0.
  - W granted for 4 cycles, then cycle 5 o_w_stall = 1 and x3 written.
  - 4 cycles later, x4 is forced the same way.
- AUX pushes x0 = 0xFF: handshake completes, count stays 0, no rd write ever occurs, mask stays 0.
- FIFO full, W idle, same-cycle push of x9 attempted: rejected (ready = 0). Head pops; next cycle ready = 1, push of x9 accepted and drains after the remaining entry in FIFO order.
- Reset asserted with 2 entries queued and counter at 3: all outputs return to reset values asynchronously; no rd write after deassertion.
